// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: state encoding, frame constants, ASCII bases.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int         DATA_BITS        = 8;
  localparam logic       START_BIT        = 1'b0;
  localparam logic       STOP_BIT         = 1'b1;
  localparam logic [7:0] ASCII_DIGIT_BASE = 8'h30;
  // 'A' (0x41) minus 10, so nibble 10..15 maps straight onto 'A'..'F'
  localparam logic [7:0] ASCII_ALPHA_BASE = 8'h37;

endpackage

// File: rtl/hex_to_ascii.sv
// Converts a 4-bit nibble into its uppercase ASCII hex digit ('0'-'9', 'A'-'F').
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input.
module hex_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] hex_in,
  output logic [7:0] ascii_out
);

  logic [7:0] w_hex_wide;

  assign w_hex_wide = {4'h0, hex_in};

  // Digits and letters sit in separate ASCII ranges, so pick the base by magnitude
  always_comb begin
    ascii_out = ASCII_DIGIT_BASE + w_hex_wide;
    if (hex_in > 4'd9) begin
      ascii_out = ASCII_ALPHA_BASE + w_hex_wide;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; optional UART_TX_HEX_EN sends data_in[3:0] as an ASCII hex digit.
// Latency: tx falls the cycle after acceptance; frame lasts 10*CLKS_PER_BIT cycles, then >=1 idle cycle.
// Backpressure: idle=1 means a byte is taken on the edge where uart_tx_ready_in=1; no queueing.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_tx_ready_in,
  input  logic [7:0] uart_tx_data_in,
  output logic       idle,
  output logic       tx
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  uart_state_t       r_state;
  logic [BAUD_W-1:0] r_baud;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_tx;
  logic              r_idle;
  logic [7:0]        w_load_byte;
  logic              w_bit_end;

`ifdef UART_TX_HEX_EN
  hex_to_ascii u_hex_to_ascii (
    .hex_in    (uart_tx_data_in[3:0]),
    .ascii_out (w_load_byte)
  );
`else
  assign w_load_byte = uart_tx_data_in;
`endif

  assign w_bit_end = (r_baud == BAUD_LAST);

  // Frame sequencer: all outputs registered so tx is glitch-free on the line
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= STOP_BIT;
      r_idle    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx      <= STOP_BIT;
          r_idle    <= 1'b1;
          r_baud    <= '0;
          r_bit_idx <= '0;
          if (uart_tx_ready_in) begin
            r_shift <= w_load_byte;
            r_state <= START;
            r_tx    <= START_BIT;
            r_idle  <= 1'b0;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_baud  <= '0;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_idx == BIT_LAST) begin
              r_state <= STOP;
              r_tx    <= STOP_BIT;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= r_shift >> 1;
              // present the next bit now so tx is registered in step with the shift
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        STOP: begin
          if (w_bit_end) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_tx    <= STOP_BIT;
            r_idle  <= 1'b1;
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= STOP_BIT;
          r_idle  <= 1'b1;
        end
      endcase
    end
  end

  assign tx   = r_tx;
  assign idle = r_idle;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=10; hex frames exercised when UART_TX_HEX_EN is defined.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx;

  logic       clk;
  logic       reset;
  logic       ready_in;
  logic [7:0] data_in;
  logic       idle;
  logic       tx;
  logic [3:0] nib;
  logic [7:0] asc;

  int checks = 0;
  int errors = 0;

  uart_tx #(.CLOCK_RATE(1000), .BAUD_RATE(100)) dut (
    .clk              (clk),
    .reset            (reset),
    .uart_tx_ready_in (ready_in),
    .uart_tx_data_in  (data_in),
    .idle             (idle),
    .tx               (tx)
  );

  hex_to_ascii u_h2a (
    .hex_in    (nib),
    .ascii_out (asc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after the acceptance edge; walks the whole frame and ends #1 after
  // the edge that returns to IDLE.
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int bi = 0; bi < 10; bi++) begin
      for (int c = 0; c < 10; c++) begin
        chk($sformatf("%s_tx_b%0d_c%0d", tag, bi, c), {7'd0, tx}, {7'd0, frame[bi]});
        chk($sformatf("%s_idle_b%0d_c%0d", tag, bi, c), {7'd0, idle}, 8'd0);
        tick();
      end
    end
    chk({tag, "_end_idle"}, {7'd0, idle}, 8'd1);
    chk({tag, "_end_tx"}, {7'd0, tx}, 8'd1);
  endtask

  initial begin
    string hexchars;
    hexchars = "0123456789ABCDEF";
    reset = 1'b1;
    ready_in = 1'b0;
    data_in = 8'h00;
    nib = 4'h0;

    // 1: reset held 3 cycles, released with ready_in=0
    tick(); tick(); tick();
    chk("rst_tx", {7'd0, tx}, 8'd1);
    chk("rst_idle", {7'd0, idle}, 8'd1);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("quiet_tx_%0d", i), {7'd0, tx}, 8'd1);
      chk($sformatf("quiet_idle_%0d", i), {7'd0, idle}, 8'd1);
    end

`ifndef UART_TX_HEX_EN
    // 2: single-cycle ready_in, 0xA5
    ready_in = 1'b1;
    data_in = 8'hA5;
    tick();
    ready_in = 1'b0;
    data_in = 8'h00;
    check_frame("a5", 8'hA5);
    tick();
    chk("a5_stay_idle", {7'd0, idle}, 8'd1);

    // 3: ready_in held high; data changes mid-frame to the second byte
    ready_in = 1'b1;
    data_in = 8'h55;
    tick();
    data_in = 8'h0F;
    check_frame("b2b1", 8'h55);
    tick();
    check_frame("b2b2", 8'h0F);
    ready_in = 1'b0;
    tick();
    chk("b2b_after_idle", {7'd0, idle}, 8'd1);
    chk("b2b_after_tx", {7'd0, tx}, 8'd1);

    // 4: reset 45 cycles into a frame, then a fresh byte
    ready_in = 1'b1;
    data_in = 8'hFE;
    tick();
    ready_in = 1'b0;
    for (int i = 0; i < 45; i++) tick();
    chk("mid_busy_idle", {7'd0, idle}, 8'd0);
    reset = 1'b1;
    tick();
    chk("abort_tx", {7'd0, tx}, 8'd1);
    chk("abort_idle", {7'd0, idle}, 8'd1);
    reset = 1'b0;
    tick();
    chk("post_abort_tx", {7'd0, tx}, 8'd1);
    ready_in = 1'b1;
    data_in = 8'h01;
    tick();
    ready_in = 1'b0;
    check_frame("x01", 8'h01);
`else
    // 5: hex mode frames carry ASCII digits
    ready_in = 1'b1;
    data_in = 8'hF3;
    tick();
    ready_in = 1'b0;
    check_frame("hex3", 8'h33);
    tick();
    ready_in = 1'b1;
    data_in = 8'h0B;
    tick();
    ready_in = 1'b0;
    check_frame("hexB", 8'h42);
`endif

    // 6: nibble to ASCII, exhaustive
    for (int i = 0; i < 16; i++) begin
      nib = 4'(i);
      #1;
      chk($sformatf("h2a_%0d", i), asc, hexchars[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
